axis_uart_serializer: RTL and testbench

AXIS_UART_SERIALIZER -- requirements
Module: axis_uart_serializer

---
 rtl/axis_uart_serializer_pkg.sv | 13 +
 rtl/axis_uart_serializer.sv | 78 +++++++
 tb/tb_axis_uart_serializer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_uart_serializer_pkg.sv
// axis_uart_serializer_pkg: shared UART constants and the serializer state encoding.
package axis_uart_serializer_pkg;

    localparam int UART_CLOCKS_PER_PULSE = 200_000_000 / 9600;
    localparam int UART_BITS_PER_WORD    = 8;

    typedef enum logic {IDLE, SEND} ser_state_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_uart_serializer.sv
// axis_uart_serializer: sends an accepted stream word as back-to-back UART frames, lowest chunk first.
module axis_uart_serializer
    import axis_uart_serializer_pkg::*;
#(
    parameter int CLOCKS_PER_PULSE = UART_CLOCKS_PER_PULSE,
    parameter int BITS_PER_WORD    = UART_BITS_PER_WORD,
    parameter int PACKET_SIZE      = BITS_PER_WORD + 5,
    parameter int W_IN             = 64
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [W_IN-1:0] s_data,
    output logic            tx,
    output logic            busy
);

    localparam int NUM_WORDS = W_IN / BITS_PER_WORD;
    localparam int PW        = cnt_width(CLOCKS_PER_PULSE);
    localparam int BW        = cnt_width(PACKET_SIZE);
    localparam int CW        = cnt_width(NUM_WORDS);
    localparam int DW        = cnt_width(W_IN);

    ser_state_t      state_q, state_d;
    logic [PW-1:0]   pulse_q, pulse_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [CW-1:0]   chunk_q, chunk_d;
    logic [W_IN-1:0] data_q;
    logic [DW-1:0]   idx;
    logic            tx_q, tx_d, p_last, b_last, c_last, accept, sending, in_data;

    assign sending = state_q == SEND;
    assign accept  = state_q == IDLE && s_valid;
    assign p_last  = pulse_q == PW'(CLOCKS_PER_PULSE - 1);
    assign b_last  = bit_q == BW'(PACKET_SIZE - 1);
    assign c_last  = chunk_q == CW'(NUM_WORDS - 1);

    always_comb begin
        state_d = state_q;
        if (accept)
            state_d = SEND;
        else if (sending && p_last && b_last && c_last)
            state_d = IDLE;
    end

    assign pulse_d = (sending && !p_last) ? pulse_q + PW'(1) : '0;
    assign bit_d   = !sending ? '0 : !p_last ? bit_q : b_last ? '0 : bit_q + BW'(1);
    assign chunk_d = !sending ? '0 : !(p_last && b_last) ? chunk_q : c_last ? '0 : chunk_q + CW'(1);

    // tx is registered from the position the counters move to, so it lines up with them
    assign in_data = bit_d >= BW'(1) && bit_d <= BW'(BITS_PER_WORD);
    assign idx     = DW'(int'(chunk_d) * BITS_PER_WORD + int'(bit_d) - 1);
    assign tx_d    = !(state_d == SEND && (bit_d == '0 || (in_data && !data_q[idx])));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            pulse_q <= '0;
            bit_q   <= '0;
            chunk_q <= '0;
            data_q  <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            pulse_q <= pulse_d;
            bit_q   <= bit_d;
            chunk_q <= chunk_d;
            data_q  <= accept ? s_data : data_q;
            tx_q    <= tx_d;
        end
    end

    assign s_ready = state_q == IDLE;
    assign busy    = !s_ready;
    assign tx      = tx_q;

endmodule

// File: tb/tb_axis_uart_serializer.sv
// tb_axis_uart_serializer: byte-level scoreboard against a behavioural UART receiver on two instances.
module tb_axis_uart_serializer;

    logic        clk = 1'b0, rstn = 1'b0;
    logic        v16 = 1'b0, v64 = 1'b0;
    logic [15:0] d16 = '0;
    logic [63:0] d64 = '0;
    logic        r16, r64, tx16, tx64, b16, b64;
    int          errors = 0, checks = 0;
    logic [7:0]  q16[$], q64[$];

    typedef struct {
        logic [15:0] data;
        logic [7:0]  lo, hi;
    } vec_t;

    always #5 clk = ~clk;

    axis_uart_serializer #(.CLOCKS_PER_PULSE(4), .BITS_PER_WORD(8), .W_IN(16)) dut (
        .clk(clk), .rstn(rstn), .s_valid(v16), .s_ready(r16), .s_data(d16), .tx(tx16), .busy(b16)
    );

    axis_uart_serializer #(.CLOCKS_PER_PULSE(4), .BITS_PER_WORD(8), .W_IN(64)) dut64 (
        .clk(clk), .rstn(rstn), .s_valid(v64), .s_ready(r64), .s_data(d64), .tx(tx64), .busy(b64)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, required %b", name, act, exp);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string msg);
        checks++;
        errors++;
        $display("FAIL %s", msg);
    endtask

    // 13-bit frame sampled mid-bit; aborts if reset is seen during the frame
    task automatic rx_frame(input bit which, output logic [12:0] f, output bit ab);
        ab = 1'b0;
        f  = '1;
        do @(negedge clk); while ((which ? tx64 : tx16) !== 1'b0);
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (!rstn) begin
                ab = 1'b1;
                break;
            end
            if (k % 4 == 2) f[k/4] = which ? tx64 : tx16;
        end
    endtask

    task automatic check_frame(input bit which, input logic [12:0] f);
        logic [7:0] e;
        chkn(which ? "loop framing" : "framing", int'({f[12:9], f[0]}), 30);
        if (which ? q64.size() == 0 : q16.size() == 0) begin
            fail($sformatf("unexpected frame: got byte %h, required none", f[8:1]));
            return;
        end
        e = which ? q64.pop_front() : q16.pop_front();
        chkn(which ? "loop byte" : "byte", int'(f[8:1]), int'(e));
    endtask

    always begin : mon16
        logic [12:0] f;
        bit          ab;
        rx_frame(1'b0, f, ab);
        if (!ab) check_frame(1'b0, f);
    end

    always begin : mon64
        logic [12:0] f;
        bit          ab;
        rx_frame(1'b1, f, ab);
        if (!ab) check_frame(1'b1, f);
    end

    task automatic wait_ready(input bit which, input string name);
        int n = 0;
        @(negedge clk);
        while (!(which ? r64 : r16) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!(which ? r64 : r16)) fail($sformatf("%s: s_ready stayed 0, required 1", name));
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((q16.size() != 0 || q64.size() != 0) && n < 60000) begin
            @(negedge clk);
            n++;
        end
        if (q16.size() != 0 || q64.size() != 0) begin
            fail($sformatf("%s: %0d bytes never received, required 0", name, q16.size() + q64.size()));
            q16.delete();
            q64.delete();
        end
    endtask

    initial begin
        vec_t        vecs[6];
        int          n;
        logic [63:0] w;
        vecs = '{'{16'hA55A, 8'h5A, 8'hA5}, '{16'h1234, 8'h34, 8'h12}, '{16'hBEEF, 8'hEF, 8'hBE},
                 '{16'h0000, 8'h00, 8'h00}, '{16'hFFFF, 8'hFF, 8'hFF}, '{16'h8001, 8'h01, 8'h80}};
        for (int i = 0; i < 6; i++) begin
            v16 = 1'($urandom);
            d16 = 16'($urandom);
            v64 = 1'($urandom);
            d64 = {$urandom, $urandom};
            @(posedge clk);
            #1;
            chk1("reset tx", tx16, 1'b1);
            chk1("reset s_ready", r16, 1'b1);
            chk1("reset busy", b16, 1'b0);
            chk1("reset tx64", tx64, 1'b1);
        end
        v16 = 1'b0;
        v64 = 1'b0;
        @(negedge clk);
        rstn = 1'b1;

        foreach (vecs[i]) begin
            wait_ready(1'b0, "vector ready");
            d16 = vecs[i].data;
            v16 = 1'b1;
            q16.push_back(vecs[i].lo);
            q16.push_back(vecs[i].hi);
            @(posedge clk);
            #1;
            v16 = 1'b0;
            chk1("start bit latency", tx16, 1'b0);
            chk1("busy after accept", b16, 1'b1);
            n = 0;
            do begin
                @(negedge clk);
                if (b16) n++;
            end while (b16 && n < 1000);
            chkn("busy cycles", n, 104);
            chk1("ready after word", r16, 1'b1);
            drain("vector drain");
        end

        wait_ready(1'b0, "b2b ready");
        d16 = 16'h1234;
        v16 = 1'b1;
        q16.push_back(8'h34);
        q16.push_back(8'h12);
        @(posedge clk);
        #1;
        d16 = 16'hBEEF;
        q16.push_back(8'hEF);
        q16.push_back(8'hBE);
        n = 0;
        while (!r16 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chkn("b2b first word length", n, 105);
        chk1("b2b idle gap tx", tx16, 1'b1);
        @(posedge clk);
        #1;
        chk1("b2b second accepted", b16, 1'b1);
        chk1("b2b second start", tx16, 1'b0);
        v16 = 1'b0;
        drain("b2b drain");

        wait_ready(1'b0, "stability ready");
        d16 = 16'h3C96;
        v16 = 1'b1;
        q16.push_back(8'h96);
        q16.push_back(8'h3C);
        @(posedge clk);
        #1;
        v16 = 1'b0;
        repeat (30) @(negedge clk);
        d16 = 16'hFFFF;
        v16 = 1'b1;
        repeat (5) @(negedge clk);
        v16 = 1'b0;
        chk1("still busy mid-send", b16, 1'b1);
        drain("stability drain");

        wait_ready(1'b0, "reset test ready");
        d16 = 16'h5555;
        v16 = 1'b1;
        q16.push_back(8'h55);
        q16.push_back(8'h55);
        @(posedge clk);
        #1;
        v16 = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        chk1("data bit 3 before reset", tx16, 1'b0);
        #1;
        rstn = 1'b0;
        #1;
        chk1("async reset tx", tx16, 1'b1);
        chk1("async reset s_ready", r16, 1'b1);
        chk1("async reset busy", b16, 1'b0);
        @(negedge clk);
        #2;
        q16.delete();
        rstn = 1'b1;
        d16 = 16'h00FF;
        v16 = 1'b1;
        q16.push_back(8'hFF);
        q16.push_back(8'h00);
        @(posedge clk);
        #1;
        v16 = 1'b0;
        chk1("accept right after reset", b16, 1'b1);
        chk1("start right after reset", tx16, 1'b0);
        drain("post-reset drain");

        for (int i = 0; i < 100; i++) begin
            wait_ready(1'b1, "loopback ready");
            w = {$urandom, $urandom};
            d64 = w;
            v64 = 1'b1;
            for (int j = 0; j < 8; j++) q64.push_back(w[8*j +: 8]);
            @(posedge clk);
            #1;
            v64 = 1'b0;
            chk1("loopback busy", b64, 1'b1);
        end
        drain("loopback drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
